// File: rtl/led_pkg.sv
// led_pkg
// Shared definitions for the LED sequencing blocks: the controller state
// encoding, the default LED bus width and the "all on" / "blank" levels
// that the controller drives when no pattern engine owns the bus.
package led_pkg;

    localparam int LED_WIDTH_DEFAULT = 18;

    localparam logic [LED_WIDTH_DEFAULT-1:0] LED_ALL_ON = '1;
    localparam logic [LED_WIDTH_DEFAULT-1:0] LED_BLANK  = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        RUN    = 2'd2,
        GAP    = 2'd3
    } led_state_t;

endpackage

// File: rtl/led_rr_pick.sv
// led_rr_pick
// Combinational wrap-around "next set bit" finder. Starting at index
// `start`, it walks the mask upwards modulo N and returns the first set
// position. Kept generic so a requester arbiter can reuse it.
//
// Ports:
//   mask   in  N      candidate bits
//   start  in  IDX_W  first index to look at
//   idx    out IDX_W  chosen index (0 when nothing is set)
//   valid  out 1      high when any mask bit is set
module led_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    // The first hit wins; later hits are masked off by the valid flag.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int off = 0; off < N; off++) begin
            cand = IDX_W'((int'(start) + off) % N);
            if (!valid && mask[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/led_state_sequencer.sv
// led_state_sequencer
// Runs the enabled LED pattern engines one at a time in round-robin order,
// with a blanking gap between patterns, and muxes the active engine's
// pattern onto the registered LED bus.
//
// Optional feature macro: LED_SEQ_WATCHDOG_EN
//   When defined, an engine running TIMEOUT cycles without finishing is
//   forced to end and the sticky timeout_flag is raised. When undefined,
//   an engine may run forever and timeout_flag is tied low.
//
// Ports:
//   clk           in  1                 system clock
//   async_rs_n    in  1                 async active-low reset, sync release
//   enabler       in  1                 run gate, low forces IDLE
//   state_mask    in  NUM_STATES        engines included in the rotation
//   st_over       in  NUM_STATES        engine done flags
//   st_out        in  NUM_STATES*WIDTH  engine patterns, engine i at [i*WIDTH +: WIDTH]
//   st_begin      out NUM_STATES        one-hot run strobe, held while active
//   out           out WIDTH             registered LED bus
//   cur_idx       out IDX_W             active or last engine index
//   cycle_done    out 1                 pulse once the rotation wraps
//   timeout_flag  out 1                 sticky watchdog flag
module led_state_sequencer
    import led_pkg::*;
#(
    parameter int NUM_STATES = 4,
    parameter int WIDTH      = LED_WIDTH_DEFAULT,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 64,
    localparam int IDX_W     = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1
) (
    input  logic                        clk,
    input  logic                        async_rs_n,
    input  logic                        enabler,
    input  logic [NUM_STATES-1:0]       state_mask,
    input  logic [NUM_STATES-1:0]       st_over,
    input  logic [NUM_STATES*WIDTH-1:0] st_out,
    output logic [NUM_STATES-1:0]       st_begin,
    output logic [WIDTH-1:0]            out,
    output logic [IDX_W-1:0]            cur_idx,
    output logic                        cycle_done,
    output logic                        timeout_flag
);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 15 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
        $error("led_state_sequencer: GAP_CYCLES or TIMEOUT out of range");
    end

    localparam logic [WIDTH-1:0] ALL_ON   = {WIDTH{LED_ALL_ON[0]}};
    localparam logic [WIDTH-1:0] BLANK    = {WIDTH{LED_BLANK[0]}};
    localparam logic [3:0]       GAP_LAST = 4'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STATES - 1);

    led_state_t            state, next_state;
    logic [IDX_W-1:0]      next_idx, search_start, pick_idx;
    logic                  pick_valid, watchdog_hit, none_above;
    logic [3:0]            gap_cnt;
    logic [NUM_STATES-1:0] begin_next;
    logic [1:0]            rst_sync;
    logic                  rst_n;

    // Reset assertion propagates straight through the async clear of the
    // synchroniser; release reaches the core two clock edges later.
    always_ff @(posedge clk or negedge async_rs_n) begin
        if (!async_rs_n) rst_sync <= 2'b00;
        else             rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    led_rr_pick #(
        .N     (NUM_STATES),
        .IDX_W (IDX_W)
    ) u_pick (
        .mask  (state_mask),
        .start (search_start),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // True when no included engine sits above the current one, so the
    // next search wraps and this rotation is complete.
    always_comb begin
        none_above = 1'b1;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (i > int'(cur_idx) && state_mask[i]) none_above = 1'b0;
        end
    end

    // Next-state logic; a low enabler overrides every state.
    always_comb begin
        next_state = state;
        next_idx   = cur_idx;
        case (state)
            IDLE: begin
                if (state_mask != '0) next_state = SELECT;
            end
            SELECT: begin
                if (pick_valid) begin
                    next_state = RUN;
                    next_idx   = pick_idx;
                end else begin
                    next_state = IDLE;
                end
            end
            RUN: begin
                if (st_over[cur_idx] || watchdog_hit) next_state = GAP;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) next_state = SELECT;
            end
            default: next_state = IDLE;
        endcase
        if (!enabler) next_state = IDLE;
    end

    // The strobe follows the state being entered so it rises on the edge
    // into RUN and drops on the edge out of it; never multi-hot.
    always_comb begin
        begin_next = '0;
        if (next_state == RUN) begin_next[next_idx] = 1'b1;
    end

    // State register, counters and the registered LED bus. The bus follows
    // the current state, giving one cycle of latency from st_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cur_idx      <= '0;
            search_start <= '0;
            gap_cnt      <= '0;
            st_begin     <= '0;
            cycle_done   <= 1'b0;
            out          <= ALL_ON;
        end else begin
            state      <= next_state;
            cur_idx    <= next_idx;
            st_begin   <= begin_next;
            cycle_done <= (state == RUN) && (next_state == GAP) && none_above;
            gap_cnt    <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;

            if (!enabler || state == IDLE) begin
                search_start <= '0;
            end else if (state == RUN && next_state == GAP) begin
                search_start <= (cur_idx == LAST_IDX) ? '0 : cur_idx + 1'b1;
            end

            if (!enabler) begin
                out <= ALL_ON;
            end else begin
                case (state)
                    IDLE:    out <= ALL_ON;
                    RUN:     out <= st_out[cur_idx*WIDTH +: WIDTH];
                    default: out <= BLANK;
                endcase
            end
        end
    end

`ifdef LED_SEQ_WATCHDOG_EN
    localparam logic [7:0] RUN_LAST = 8'(TIMEOUT - 1);

    logic [7:0] run_cnt;

    assign watchdog_hit = (state == RUN) && (run_cnt == RUN_LAST);

    // Run counter restarts for every engine; the flag is sticky until the
    // sequencer is disabled or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            run_cnt <= (state == RUN && next_state == RUN) ? run_cnt + 8'd1 : 8'd0;
            if (!enabler) begin
                timeout_flag <= 1'b0;
            end else if (watchdog_hit && !st_over[cur_idx]) begin
                timeout_flag <= 1'b1;
            end
        end
    end
`else
    assign watchdog_hit = 1'b0;
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_led_state_sequencer.sv
// tb_led_state_sequencer
// Directed bench for led_state_sequencer: a cycle-by-cycle vector table
// with st_over driven directly, followed by hand-written sequences that use
// a small engine model (raises st_over after a set number of active cycles).
module tb_led_state_sequencer;

    typedef struct {
        logic        en;
        logic [3:0]  mask;
        logic [3:0]  over;
        logic [3:0]  exp_begin;
        logic [17:0] exp_out;
        logic [1:0]  exp_idx;
        logic        exp_cd;
    } vec_t;

    logic        clk = 1'b0;
    logic        async_rs_n = 1'b0;
    logic        enabler = 1'b0;
    logic [3:0]  state_mask = 4'b0000;
    logic [3:0]  tbl_over = 4'b0000;
    logic [3:0]  eng_over = 4'b0000;
    logic        use_engines = 1'b0;
    logic [3:0]  st_over;
    logic [17:0] pat [4];
    logic [71:0] st_out;
    logic [3:0]  st_begin;
    logic [17:0] out;
    logic [1:0]  cur_idx;
    logic        cycle_done;
    logic        timeout_flag;

    int run_len [4];
    int eng_cnt [4];
    int checks = 0;
    int failures = 0;

    vec_t vq[$];

    always #5 clk = ~clk;

    assign st_over = use_engines ? eng_over : tbl_over;
    assign st_out  = {pat[3], pat[2], pat[1], pat[0]};

    led_state_sequencer dut (
        .clk          (clk),
        .async_rs_n   (async_rs_n),
        .enabler      (enabler),
        .state_mask   (state_mask),
        .st_over      (st_over),
        .st_out       (st_out),
        .st_begin     (st_begin),
        .out          (out),
        .cur_idx      (cur_idx),
        .cycle_done   (cycle_done),
        .timeout_flag (timeout_flag)
    );

    // Engine model: counts its own active cycles and reports done once the
    // programmed length is reached (length 0 means it never finishes).
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (st_begin[i]) eng_cnt[i] = eng_cnt[i] + 1;
            else             eng_cnt[i] = 0;
            eng_over[i] = st_begin[i] && (run_len[i] != 0) && (eng_cnt[i] >= run_len[i]);
        end
    end

    // Hard stop so a stuck run still ends with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running, want finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        enabler    = v.en;
        state_mask = v.mask;
        tbl_over   = v.over;
    endtask

    task automatic addVec(input logic en, input logic [3:0] mask, input logic [3:0] over,
                          input logic [3:0] eb, input logic [17:0] eo,
                          input logic [1:0] ei, input logic ec);
        vec_t v;
        v.en = en; v.mask = mask; v.over = over;
        v.exp_begin = eb; v.exp_out = eo; v.exp_idx = ei; v.exp_cd = ec;
        vq.push_back(v);
    endtask

    initial begin
        logic [3:0] rv[$];
        int         rl[$];
        int         rs[$];
        logic [3:0] ev [10];
        int         el [10];
        int         oh_bad, cd_count, cd_idx, budget, hi;

        pat[0] = 18'h15555; pat[1] = 18'h2AAAA; pat[2] = 18'h0F0F0; pat[3] = 18'h30303;
        for (int i = 0; i < 4; i++) run_len[i] = 10;

        // Reset held low across clock edges.
        @(negedge clk); @(negedge clk);
        checkOutput("reset out",          32'(out),          32'h3FFFF);
        checkOutput("reset st_begin",     32'(st_begin),     32'h0);
        checkOutput("reset cur_idx",      32'(cur_idx),      32'h0);
        checkOutput("reset cycle_done",   32'(cycle_done),   32'h0);
        checkOutput("reset timeout_flag", 32'(timeout_flag), 32'h0);
        async_rs_n = 1'b1;
        repeat (3) @(negedge clk);

        // Vector table: en, mask, over -> st_begin, out, cur_idx, cycle_done.
        addVec(1, 4'b1010, 4'b0000, 4'b0000, 18'h3FFFF, 2'd0, 0);
        addVec(1, 4'b1010, 4'b0000, 4'b0010, 18'h00000, 2'd1, 0);
        addVec(1, 4'b1010, 4'b0000, 4'b0010, 18'h2AAAA, 2'd1, 0);
        addVec(1, 4'b1010, 4'b0010, 4'b0000, 18'h2AAAA, 2'd1, 0);
        addVec(1, 4'b1010, 4'b0000, 4'b0000, 18'h00000, 2'd1, 0);
        addVec(1, 4'b1010, 4'b0000, 4'b0000, 18'h00000, 2'd1, 0);
        addVec(1, 4'b1010, 4'b0000, 4'b1000, 18'h00000, 2'd3, 0);
        addVec(1, 4'b1010, 4'b0001, 4'b1000, 18'h30303, 2'd3, 0);
        addVec(1, 4'b1010, 4'b1000, 4'b0000, 18'h30303, 2'd3, 1);
        addVec(1, 4'b1010, 4'b0000, 4'b0000, 18'h00000, 2'd3, 0);
        addVec(1, 4'b1010, 4'b0000, 4'b0000, 18'h00000, 2'd3, 0);
        addVec(1, 4'b1010, 4'b0000, 4'b0010, 18'h00000, 2'd1, 0);
        addVec(1, 4'b1010, 4'b0000, 4'b0010, 18'h2AAAA, 2'd1, 0);
        addVec(1, 4'b0100, 4'b0000, 4'b0010, 18'h2AAAA, 2'd1, 0);
        addVec(1, 4'b0100, 4'b0010, 4'b0000, 18'h2AAAA, 2'd1, 0);
        addVec(1, 4'b0100, 4'b0000, 4'b0000, 18'h00000, 2'd1, 0);
        addVec(1, 4'b0100, 4'b0000, 4'b0000, 18'h00000, 2'd1, 0);
        addVec(1, 4'b0100, 4'b0000, 4'b0100, 18'h00000, 2'd2, 0);
        addVec(0, 4'b0100, 4'b0000, 4'b0000, 18'h3FFFF, 2'd2, 0);
        addVec(1, 4'b0000, 4'b0000, 4'b0000, 18'h3FFFF, 2'd2, 0);
        addVec(1, 4'b0000, 4'b0000, 4'b0000, 18'h3FFFF, 2'd2, 0);
        addVec(1, 4'b0001, 4'b0000, 4'b0000, 18'h3FFFF, 2'd2, 0);
        addVec(1, 4'b0000, 4'b0000, 4'b0000, 18'h00000, 2'd2, 0);
        addVec(1, 4'b0000, 4'b0000, 4'b0000, 18'h3FFFF, 2'd2, 0);
        addVec(1, 4'b1000, 4'b0000, 4'b0000, 18'h3FFFF, 2'd2, 0);
        addVec(1, 4'b1000, 4'b0000, 4'b1000, 18'h00000, 2'd3, 0);
        addVec(1, 4'b1000, 4'b1000, 4'b0000, 18'h30303, 2'd3, 1);
        addVec(1, 4'b1000, 4'b0000, 4'b0000, 18'h00000, 2'd3, 0);
        addVec(1, 4'b1000, 4'b0000, 4'b0000, 18'h00000, 2'd3, 0);
        addVec(1, 4'b1000, 4'b0000, 4'b1000, 18'h00000, 2'd3, 0);
        addVec(0, 4'b1000, 4'b0000, 4'b0000, 18'h3FFFF, 2'd3, 0);

        for (int i = 0; i < vq.size(); i++) begin
            applyStimulus(vq[i]);
            @(negedge clk);
            checkOutput($sformatf("v%0d st_begin", i),   32'(st_begin),   32'(vq[i].exp_begin));
            checkOutput($sformatf("v%0d out", i),        32'(out),        32'(vq[i].exp_out));
            checkOutput($sformatf("v%0d cur_idx", i),    32'(cur_idx),    32'(vq[i].exp_idx));
            checkOutput($sformatf("v%0d cycle_done", i), 32'(cycle_done), 32'(vq[i].exp_cd));
        end

        // Full rotation with engines finishing after 10 active cycles.
        ev[0] = 4'b0001; ev[1] = 4'b0000; ev[2] = 4'b0010; ev[3] = 4'b0000; ev[4] = 4'b0100;
        ev[5] = 4'b0000; ev[6] = 4'b1000; ev[7] = 4'b0000; ev[8] = 4'b0001; ev[9] = 4'b0000;
        for (int i = 0; i < 10; i++) el[i] = (i % 2 == 0) ? 10 : 3;
        use_engines = 1'b1;
        tbl_over    = 4'b0000;
        state_mask  = 4'b1111;
        enabler     = 1'b1;
        oh_bad = 0; cd_count = 0; cd_idx = -1;
        for (int s = 0; s < 70; s++) begin
            @(negedge clk);
            if (!$onehot0(st_begin)) oh_bad++;
            if (cycle_done) begin
                cd_count++;
                cd_idx = s;
            end
            if (rv.size() == 0 || st_begin != rv[rv.size()-1]) begin
                rv.push_back(st_begin);
                rl.push_back(1);
                rs.push_back(s);
            end else begin
                rl[rl.size()-1] = rl[rl.size()-1] + 1;
            end
        end
        checkOutput("rotation onehot0 violations", 32'(oh_bad), 32'd0);
        checkOutput("rotation segment count ok", 32'(rv.size() >= 11), 32'd1);
        if (rv.size() >= 11) begin
            for (int i = 0; i < 10; i++) begin
                checkOutput($sformatf("rotation seg%0d st_begin", i + 1), 32'(rv[i+1]), 32'(ev[i]));
                checkOutput($sformatf("rotation seg%0d length", i + 1),   32'(rl[i+1]), 32'(el[i]));
            end
            checkOutput("rotation cycle_done count", 32'(cd_count), 32'd1);
            checkOutput("rotation cycle_done after engine3", 32'(cd_idx), 32'(rs[8]));
        end

        // Drop enabler in the gap that follows engine 1.
        budget = 0;
        while (st_begin != 4'b0000 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("gap after engine1 st_begin", 32'(st_begin), 32'h0);
        checkOutput("gap after engine1 cur_idx",  32'(cur_idx),  32'd1);
        enabler = 1'b0;
        @(negedge clk);
        checkOutput("disable out",        32'(out),        32'h3FFFF);
        checkOutput("disable st_begin",   32'(st_begin),   32'h0);
        checkOutput("disable cycle_done", 32'(cycle_done), 32'h0);
        enabler = 1'b1;
        budget = 0;
        while (st_begin == 4'b0000 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("re-enable first engine st_begin", 32'(st_begin), 32'b0001);
        checkOutput("re-enable first engine cur_idx",  32'(cur_idx),  32'd0);

        // One-cycle latency from st_out to out.
        pat[0] = 18'h12345;
        #1;
        checkOutput("out before edge", 32'(out), 32'h0);
        @(negedge clk);
        checkOutput("out one edge later", 32'(out), 32'h12345);
        checkOutput("engine0 still running", 32'(st_begin), 32'b0001);

        // Asynchronous reset in the middle of RUN.
        #2 async_rs_n = 1'b0;
        #1;
        checkOutput("async reset out",        32'(out),        32'h3FFFF);
        checkOutput("async reset st_begin",   32'(st_begin),   32'h0);
        checkOutput("async reset cycle_done", 32'(cycle_done), 32'h0);
        checkOutput("async reset cur_idx",    32'(cur_idx),    32'h0);

        // Engine 2 never finishes.
        run_len[0] = 3; run_len[1] = 3; run_len[2] = 0; run_len[3] = 3;
        @(negedge clk);
        async_rs_n = 1'b1;
        budget = 0;
        while (st_begin != 4'b0100 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("engine2 selected", 32'(st_begin), 32'b0100);
        hi = 0;
`ifdef LED_SEQ_WATCHDOG_EN
        while (st_begin[2] && hi < 300) begin
            hi++;
            @(negedge clk);
        end
        checkOutput("watchdog engine2 high cycles", 32'(hi), 32'd64);
        checkOutput("watchdog timeout_flag", 32'(timeout_flag), 32'd1);
        budget = 0;
        while (st_begin == 4'b0000 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("watchdog next engine", 32'(st_begin), 32'b1000);
`else
        while (st_begin[2] && hi < 200) begin
            hi++;
            @(negedge clk);
        end
        checkOutput("no watchdog engine2 held", 32'(hi), 32'd200);
        checkOutput("no watchdog timeout_flag", 32'(timeout_flag), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_state_sequencer.md
# led_state_sequencer

Top-level controller for the LED pattern engines (stage-1 to stage-4 style blocks with `stBegin`/`enabler` inputs and `stOver` outputs). It runs the enabled engines one at a time in a fixed round-robin order and inserts a blanking gap between patterns. It multiplexes the active engine's 18-bit pattern onto the LED bus and reports cycle completion. It sits between the board-level enable/mask inputs and the pattern-engine array.

## Interface
- `NUM_STATES`, 4: number of pattern engines sequenced; index width `IDX_W = $clog2(NUM_STATES)`.
- `WIDTH`, 18: LED bus width.
- `GAP_CYCLES`, 2: blank cycles between patterns, 1..15.
- `TIMEOUT`, 64: max cycles an engine may run before forced advance (only with watchdog), 2..255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `async_rs_n`  in  1  asynchronous, active-low reset. Assertion resets immediately; deassertion is taken synchronously to `clk`.
- `enabler`  in  1  run gate; low forces IDLE.
- `state_mask`  in  NUM_STATES  bit i = 1 includes engine i in the sequence; sampled at every engine selection.
- `st_over`  in  NUM_STATES  done flags from the engines.
- `st_out`  in  NUM_STATES*WIDTH  engine patterns; engine i occupies bits [i*WIDTH +: WIDTH].
- `st_begin`  out  NUM_STATES  one-hot run strobe to the engines; held high while that engine is active.
- `out`  out  WIDTH  registered LED bus.
- `cur_idx`  out  IDX_W  index of the active or last engine.
- `cycle_done`  out  1  one-cycle pulse after the last enabled engine in the order finishes.
- `timeout_flag`  out  1  sticky watchdog flag; constant 0 without the watchdog.

## Operation
- States: IDLE, SELECT, RUN, GAP.
- Reset values: state IDLE, `st_begin` = 0, `out` = all ones, `cur_idx` = 0, `cycle_done` = 0, `timeout_flag` = 0, gap/run counters = 0.
- IDLE: `out` = all ones, `st_begin` = 0.
  - Go to SELECT when `enabler` = 1 and `state_mask` != 0.
  - The first selection searches from index 0.
- SELECT (1 cycle):
  - Pick the lowest set mask bit at or after the search start, wrapping modulo NUM_STATES.
  - Load that value into `cur_idx`, then go to RUN.
  - If the mask is now 0, return to IDLE.
- RUN:
  - `st_begin[cur_idx]` = 1; `out` <= slice `cur_idx` of `st_out`.
  - The run counter increments each cycle.
  - On a sampled `st_over[cur_idx]` = 1: clear `st_begin` and go to GAP. Deasserting begin resets the engine.
  - `st_over` bits of inactive engines are ignored.
- GAP: `out` = 0 for GAP_CYCLES cycles, then SELECT with search start `cur_idx`+1 (wrapping).
- `cycle_done` pulses in the first GAP cycle when no mask bit exists above `cur_idx`, i.e. the next search wraps.
- `enabler` = 0 in any state: IDLE on the next edge. `st_begin` and `cycle_done` clear, `out` = all ones, the search start resets to 0.
- A single-engine mask reruns the same engine after every GAP.
- A mask change during RUN does not abort the active engine; it takes effect at the next SELECT.
- Reset mid-RUN: all outputs return to their reset values asynchronously.

## Timing
- `out` latency: 1 cycle from `st_out` to `out` in RUN.
- `st_begin` rises on the edge that enters RUN, i.e. 2 edges after `enabler` is first seen high in IDLE.
- `st_over` sampled high at edge N: `st_begin` is low after edge N+1 and `out` = 0 from N+1.
- Engine-to-engine gap: GAP_CYCLES + 1 (SELECT) cycles with `st_begin` all zero.
- `st_begin` is never multi-hot, including across the RUN to GAP to RUN transition.

## Configuration
- `LED_SEQ_WATCHDOG_EN` defined:
  - In RUN, when the run counter reaches TIMEOUT-1 without `st_over`, treat the engine as finished: go to GAP and set `timeout_flag`.
  - `timeout_flag` stays set until reset or until `enabler` = 0.
- Not defined: no run counter and no forced advance; `timeout_flag` is tied to 0. An engine that never finishes holds RUN indefinitely.

## Structure
- Shared package `led_pkg`: state enum (IDLE, SELECT, RUN, GAP), `LED_ALL_ON` / `LED_BLANK` constants, default WIDTH.
- One sub-module `led_rr_pick`: combinational wrap-around next-set-bit finder taking mask and start index and returning index plus valid. It is reused by the future requester arbiter.
- The next-state FSM, counters and output mux live in the top module.

## Test plan
- Reset: `async_rs_n` = 0 mid-RUN -> immediately `out` = 18'h3FFFF, `st_begin` = 0, `cycle_done` = 0.
- Full rotation, mask 4'b1111, each engine raising `st_over` after 10 cycles -> `st_begin` sequence 0001, 0010, 0100, 1000, 0001, each separated by 3 zero cycles (GAP_CYCLES = 2). `cycle_done` pulses once after engine 3.
- Sparse mask 4'b1010 -> only engines 1 and 3 are run, alternating. `cycle_done` pulses after engine 3; engine 0 never sees `st_begin`.
- `enabler` dropped during the GAP after engine 1 -> IDLE next edge, `out` = 18'h3FFFF. On re-enable, the first selected engine is engine 0.
- Watchdog build, engine 2 never asserts `st_over`, TIMEOUT = 64 -> `st_begin[2]` is high for exactly 64 cycles, then `timeout_flag` = 1 and engine 3 is selected. Non-watchdog build -> `st_begin[2]` stays high.
- Mask 4'b0000 with `enabler` = 1 -> remains IDLE and `st_begin` stays 0.
